// File: rtl/mips_gpio_mmio.sv
// mips_gpio_mmio
//   Memory-mapped GPIO responder for MIPS_Multi_Cycle, placed behind the
//   data-memory address decode. Four word registers selected by addr[3:2]:
//     0 OUT    (RW)  drives GPIO_o
//     1 IN     (RO)  synchronized + debounced GPIO_i
//     2 RISE   (R/W1C) sticky rising-edge capture of IN
//     3 IRQ_EN (RW)  per-bit interrupt mask for RISE
//
// Ports
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   addr    byte address within the block (addr[1:0] ignored)
//   we, re  one-cycle write / read strobes
//   wdata   write data
//   rdata   registered read data, valid the cycle after re, held until next re
//   GPIO_i  asynchronous external inputs
//   GPIO_o  external outputs (OUT register)
//   irq     registered (RISE & IRQ_EN) != 0
module mips_gpio_mmio #(
  parameter int              WIDTH      = 8,
  parameter int              DEB_CYCLES = 4,
  parameter logic [WIDTH-1:0] OUT_RST   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] GPIO_i,
  output logic [WIDTH-1:0] GPIO_o,
  output logic             irq
);

  localparam int              CNT_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_RISE = 2'd2;
  localparam logic [1:0] REG_EN   = 2'd3;

  logic [WIDTH-1:0] out_q, in_q, rise_q, en_q;
  logic [WIDTH-1:0] in_d, rise_d;
  logic [WIDTH-1:0] sync_p0, sync_p1;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [31:0]      rd_mux;
  logic [1:0]       sel;
  logic [WIDTH-1:0] wbits;
  logic             wr_out, wr_rise, wr_en;

  // Byte-lane bits and upper write bits beyond WIDTH carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  assign sel     = addr[3:2];
  assign wbits   = wdata[WIDTH-1:0];
  assign wr_out  = we && (sel == REG_OUT);
  assign wr_rise = we && (sel == REG_RISE);
  assign wr_en   = we && (sel == REG_EN);

  // Debounce: a bit of IN only follows the synchronized input after
  // DEB_CYCLES consecutive edges on which the two disagree.
  always_comb begin
    in_d = in_q;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d[b] = '0;
      if (sync_p1[b] != in_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          in_d[b] = sync_p1[b];
        end else if (cnt_q[b] != CNT_MAX) begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end else begin
          cnt_d[b] = cnt_q[b];
        end
      end
    end
  end

  // Clear is applied before the new edge is ORed in, so a rising edge on the
  // same cycle as a W1C of that bit survives.
  always_comb begin
    rise_d = rise_q;
    if (wr_rise) rise_d = rise_d & ~wbits;
    rise_d = rise_d | (in_d & ~in_q);
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_OUT:  rd_mux[WIDTH-1:0] = out_q;
      REG_IN:   rd_mux[WIDTH-1:0] = in_q;
      REG_RISE: rd_mux[WIDTH-1:0] = rise_q;
      default:  rd_mux[WIDTH-1:0] = en_q;
    endcase
  end

  // Synchronizer stage: GPIO_i -> sync_p0 -> sync_p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= GPIO_i;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce / edge-capture / bus register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= OUT_RST;
      in_q   <= '0;
      rise_q <= '0;
      en_q   <= '0;
      rdata  <= '0;
      irq    <= 1'b0;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
    end else begin
      in_q   <= in_d;
      rise_q <= rise_d;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
      if (wr_out) out_q <= wbits;
      if (wr_en)  en_q  <= wbits;
      // rd_mux sees pre-write state, so a simultaneous re/we returns old data.
      if (re)     rdata <= rd_mux;
      irq <= |(rise_q & en_q);
    end
  end

  assign GPIO_o = out_q;

endmodule

// File: tb/tb_mips_gpio_mmio.sv
module tb_mips_gpio_mmio;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
  localparam int HMAX  = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       addr = '0;
  logic             we = 1'b0;
  logic             re = 1'b0;
  logic [31:0]      wdata = '0;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] GPIO_i = '0;
  logic [WIDTH-1:0] GPIO_o;
  logic             irq;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  mips_gpio_mmio #(.WIDTH(WIDTH), .DEB_CYCLES(DEB), .OUT_RST(8'h00)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .GPIO_i(GPIO_i), .GPIO_o(GPIO_o), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // IN is derived from the raw input history: the synchronized sample used at
  // edge e is the GPIO_i value seen at edge e-2, and a bit flips when the last
  // DEB such samples (all after its previous flip) disagree with it.
  logic [WIDTH-1:0] hist [HMAX];
  int               last_flip [WIDTH];
  int               k;
  logic [WIDTH-1:0] m_out, m_in, m_rise, m_en;
  logic [31:0]      m_rdata;
  logic             m_irq;

  function automatic logic s2_at(int e, int b);
    if (e < 2 || e - 2 >= HMAX) return 1'b0;
    return hist[e-2][b];
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [WIDTH-1:0] old_in, new_in, clr;
    logic             new_irq, ok;
    if (reset) begin
      m_out = '0; m_in = '0; m_rise = '0; m_en = '0;
      m_rdata = '0; m_irq = 1'b0; k = 0;
      for (int b = 0; b < WIDTH; b++) last_flip[b] = -1;
    end else begin
      if (k < HMAX) hist[k] = GPIO_i;
      old_in = m_in;
      new_in = m_in;
      for (int b = 0; b < WIDTH; b++) begin
        if (k - DEB + 1 > last_flip[b]) begin
          ok = 1'b1;
          for (int i = 0; i < DEB; i++)
            if (s2_at(k - i, b) == m_in[b]) ok = 1'b0;
          if (ok) begin
            new_in[b] = ~m_in[b];
            last_flip[b] = k;
          end
        end
      end
      if (re) begin
        m_rdata = '0;
        case (addr[3:2])
          2'd0: m_rdata[WIDTH-1:0] = m_out;
          2'd1: m_rdata[WIDTH-1:0] = m_in;
          2'd2: m_rdata[WIDTH-1:0] = m_rise;
          default: m_rdata[WIDTH-1:0] = m_en;
        endcase
      end
      new_irq = (m_rise & m_en) != '0;
      clr = '0;
      if (we) begin
        case (addr[3:2])
          2'd0: m_out = wdata[WIDTH-1:0];
          2'd2: clr = wdata[WIDTH-1:0];
          2'd3: m_en = wdata[WIDTH-1:0];
          default: ;
        endcase
      end
      m_rise = (m_rise & ~clr) | (new_in & ~old_in);
      m_in = new_in;
      m_irq = new_irq;
      k++;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("cyc_gpio_o", 32'(GPIO_o), 32'(m_out));
      chk("cyc_irq", 32'(irq), 32'(m_irq));
      chk("cyc_rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    started = 1'b1;
    chk("rst_gpio_o", 32'(GPIO_o), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Mid-cycle asynchronous reset with OUT=0x5A
    bus_write(4'h0, 32'h0000_005A);
    chk("out_5a", 32'(GPIO_o), 32'h5A);
    #3 reset = 1'b1;
    #1 chk("async_rst_gpio_o", 32'(GPIO_o), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    bus_read(4'h0, rd);
    chk("post_rst_lw_out", rd, 32'h0);

    // OUT write / readback, write to IN ignored
    bus_write(4'h0, 32'hFFFF_FFA5);
    chk("out_a5_next", 32'(GPIO_o), 32'hA5);
    bus_read(4'h0, rd);
    chk("lw_out_a5", rd, 32'h0000_00A5);
    bus_write(4'h4, 32'h0000_0033);
    bus_read(4'h4, rd);
    chk("in_ro", rd, 32'h0);

    // Debounce latency: IN is 0xFF after exactly 6 edges
    GPIO_i = 8'hFF;
    addr = 4'h4; re = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("deb_lat_%0d", i), rdata, (i < 6) ? 32'h0 : 32'hFF);
    end
    re = 1'b0;
    bus_read(4'h8, rd);
    chk("rise_ff", rd, 32'hFF);

    // Glitch shorter than DEB is filtered, no new RISE bits
    bus_write(4'h8, 32'hFF);
    GPIO_i = 8'h00;
    repeat (3) tick();
    GPIO_i = 8'hFF;
    repeat (8) tick();
    bus_read(4'h4, rd);
    chk("glitch_in", rd, 32'hFF);
    bus_read(4'h8, rd);
    chk("glitch_rise", rd, 32'h0);

    // Edge capture and irq; falling edge not captured
    GPIO_i = 8'h00;
    repeat (8) tick();
    bus_read(4'h8, rd);
    chk("fall_no_rise", rd, 32'h0);
    bus_write(4'hC, 32'h01);
    GPIO_i = 8'h01;
    repeat (6) tick();
    chk("irq_before", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    bus_write(4'h8, 32'h01);
    bus_read(4'h8, rd);
    chk("rise_cleared", rd, 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Set beats W1C on the same edge
    GPIO_i = 8'h00;
    repeat (8) tick();
    GPIO_i = 8'h01;
    repeat (5) tick();
    bus_write(4'h8, 32'h01);
    bus_read(4'h8, rd);
    chk("set_wins", rd, 32'h01);

    // Read/write collision returns pre-write data
    bus_write(4'h0, 32'h11);
    addr = 4'h0; wdata = 32'h22; re = 1'b1; we = 1'b1;
    tick();
    re = 1'b0; we = 1'b0;
    chk("coll_rdata", rdata, 32'h11);
    chk("coll_gpio_o", 32'(GPIO_o), 32'h22);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
